// File: rtl/l2_responder_pkg.sv
// -----------------------------------------------------------------------------
// l2_responder_pkg
// Shared bus-controller types used by the L2 responder and its bench:
//   BLOCK_SIZE / DATA_WIDTH : words per transfer and transfer width in bits
//   word_t                  : 32-bit bus word / byte address
//   transfer_width_t        : one block transfer
//   l2_state_t              : L2 port progress encoding seen by the bus controller
//   l2_op_t                 : latched request kind inside the responder
// -----------------------------------------------------------------------------
package l2_responder_pkg;

    localparam int BLOCK_SIZE = 2;
    localparam int DATA_WIDTH = 32 * BLOCK_SIZE;

    typedef logic [31:0]           word_t;
    typedef logic [DATA_WIDTH-1:0] transfer_width_t;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } l2_op_t;

endpackage

// File: rtl/l2_responder_if.sv
// -----------------------------------------------------------------------------
// l2_responder_if
// L2 port between the coherence bus controller (master) and the L2 (slave).
//   l2REN / l2WEN : read / write request levels, held until completion
//   l2addr        : block byte address
//   l2store       : write data
//   l2load        : read data (driven by the L2)
//   l2state       : L2 progress state (driven by the L2)
// -----------------------------------------------------------------------------
interface l2_responder_if
    import l2_responder_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) ();

    logic          l2REN;
    logic          l2WEN;
    word_t         l2addr;
    logic [DW-1:0] l2store;
    logic [DW-1:0] l2load;
    l2_state_t     l2state;

    modport master (
        output l2REN, l2WEN, l2addr, l2store,
        input  l2load, l2state
    );

    modport slave (
        input  l2REN, l2WEN, l2addr, l2store,
        output l2load, l2state
    );

endinterface

// File: rtl/l2_backing_store.sv
// -----------------------------------------------------------------------------
// l2_backing_store
// Single-port synchronous RAM holding DEPTH blocks of DW bits. Read data is
// registered: rdata reflects mem[idx] as addressed at the previous edge.
// Contents are never reset.
//   clk   : clock
//   we    : write enable, writes wdata to mem[idx]
//   idx   : block index
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module l2_backing_store
    import l2_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DW    = DATA_WIDTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/l2_responder.sv
// -----------------------------------------------------------------------------
// l2_responder
// Cycle-level L2 stand-in for the coherence bus controller. Accepts one read
// or write at a time, spends LATENCY cycles in L2_BUSY, reports one L2_ACCESS
// cycle, and flags illegal requests with L2_ERROR.
//   clk  : clock, rising edge
//   nRST : synchronous active-low reset
//   bus  : L2 port (slave side): l2REN, l2WEN, l2addr, l2store in;
//          l2load, l2state out (both registered)
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// L2_FREE   | idle, sampling for a new request
// L2_BUSY   | request latched, down-counter running toward completion
// L2_ACCESS | one-cycle completion; l2load valid for reads
// L2_ERROR  | illegal request seen; held until both requests drop
// -----------------------------------------------------------------------------
module l2_responder
    import l2_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = l2_responder_pkg::BLOCK_SIZE,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 4
) (
    input  logic          clk,
    input  logic          nRST,
    l2_responder_if.slave bus
);

    localparam int DW    = 32 * BLOCK_SIZE;
    localparam int OFS   = $clog2(DW / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    l2_state_t        state_q, state_d;
    l2_op_t           op_q,    op_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [DW-1:0]    load_q,  load_d;

    logic [IDX_W-1:0] req_idx;
    logic             misaligned;
    logic             out_of_range;
    logic             any_req;
    logic             one_req;

    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [DW-1:0]    ram_rdata;

    assign req_idx      = bus.l2addr[OFS +: IDX_W];
    assign misaligned   = |bus.l2addr[OFS-1:0];
    assign out_of_range = |bus.l2addr[31:OFS+IDX_W];
    assign any_req      = bus.l2REN | bus.l2WEN;
    assign one_req      = bus.l2REN ^ bus.l2WEN;

    l2_backing_store #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IDX_W (IDX_W)
    ) u_store (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q <= L2_FREE;
            op_q    <= OP_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        ram_we  = 1'b0;
        ram_idx = idx_q;

        unique case (state_q)
            L2_FREE: begin
                // Address the RAM with the incoming index while idle so the
                // registered read is already valid after the first BUSY edge,
                // which matters when LATENCY is 1.
                ram_idx = req_idx;
                if (any_req) begin
                    if (one_req && !misaligned && !out_of_range) begin
                        state_d = L2_BUSY;
                        op_d    = bus.l2WEN ? OP_WRITE : OP_READ;
                        idx_d   = req_idx;
                        wdata_d = bus.l2store;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_d = L2_ERROR;
                        load_d  = '0;
                    end
                end
            end

            L2_BUSY: begin
                if (!any_req) begin
                    state_d = L2_FREE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (op_q == OP_READ) begin
                        load_d = ram_rdata;
                    end else begin
                        ram_we = 1'b1;
                    end
                    state_d = L2_ACCESS;
                end
            end

            L2_ACCESS: begin
                state_d = L2_FREE;
            end

            L2_ERROR: begin
                if (!any_req) begin
                    state_d = L2_FREE;
                end
            end

            default: begin
                state_d = L2_FREE;
            end
        endcase
    end

    assign bus.l2load  = load_q;
    assign bus.l2state = state_q;

endmodule
